// File: rtl/sequenciador_de_execucao.sv
// Multi-cycle execution sequencer: gates PC/register/memory commits for MUL/DIV, IN, OUT and HALT.
// Optional single-step mode is enabled with the SINGLE_STEP_EN macro.
module sequenciador_de_execucao #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       f3,
  input  logic [6:0]       f7,
  input  logic             regWrite_in,
  input  logic             MemWrite_in,
  input  logic             confirm,
  input  logic [31:0]      rs1_data,
`ifdef SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_we,
  output logic             alu_busy,
  output logic             wait_in,
  output logic             halted,
  output logic [31:0]      disp_out,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);
  localparam logic [6:0] OP_ALU  = 7'd51;
  localparam logic [6:0] OP_IN   = 7'd55;
  localparam logic [6:0] OP_HALT = 7'd63;
  localparam logic [6:0] OP_OUT  = 7'd23;

  typedef enum logic [1:0] {S_RUN, S_MULTI, S_WAIT_IN, S_HALTED} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             conf_prev_q, conf_prev_d;
  logic [31:0]      disp_q, disp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit;
  logic             conf_rise;
  logic             run_ok;
  logic             mul_long, div_long, is_out, holds_pc;

  assign conf_rise = confirm & ~conf_prev_q;
  assign mul_long  = (opcode == OP_ALU) && (f3 == 3'd3) && (f7 == 7'd0)  && (MUL_CYCLES > 1);
  assign div_long  = (opcode == OP_ALU) && (f3 == 3'd3) && (f7 == 7'd32) && (DIV_CYCLES > 1);
  assign is_out    = (opcode == OP_OUT);
  // Instructions that leave RUN without retiring in this cycle
  assign holds_pc  = mul_long || div_long || (opcode == OP_IN) || (opcode == OP_HALT);

`ifdef SINGLE_STEP_EN
  logic step_prev_q, step_prev_d;
  assign step_prev_d = step;
  assign run_ok      = ~step_mode | (step & ~step_prev_q);

  always_ff @(posedge clk) begin
    if (reset) step_prev_q <= 1'b1;
    else       step_prev_q <= step_prev_d;
  end
`else
  assign run_ok = 1'b1;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      conf_prev_q <= 1'b1;
      disp_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      conf_prev_q <= conf_prev_d;
      disp_q      <= disp_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (run_ok) begin
          if (mul_long) begin
            state_d = S_MULTI;
            cnt_d   = MUL_LOAD;
          end else if (div_long) begin
            state_d = S_MULTI;
            cnt_d   = DIV_LOAD;
          end else if (opcode == OP_IN) begin
            state_d = S_WAIT_IN;
          end else if (opcode == OP_HALT) begin
            state_d = S_HALTED;
          end
        end
      end
      S_MULTI: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WAIT_IN: begin
        if (conf_rise) state_d = S_RUN;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // Outputs and commit gating; reset aborts any commit in flight
  always_comb begin
    commit      = 1'b0;
    alu_busy    = 1'b0;
    wait_in     = 1'b0;
    halted      = 1'b0;
    disp_d      = disp_q;
    conf_prev_d = confirm;
    case (state_q)
      S_RUN: begin
        if (run_ok && !holds_pc) commit = 1'b1;
        if (run_ok && is_out)    disp_d = rs1_data;
      end
      S_MULTI: begin
        alu_busy = 1'b1;
        commit   = (cnt_q == '0);
      end
      S_WAIT_IN: begin
        wait_in = 1'b1;
        commit  = conf_rise;
      end
      S_HALTED: halted = 1'b1;
      default:  commit = 1'b0;
    endcase
    if (reset) commit = 1'b0;
    pc_en   = commit;
    reg_we  = regWrite_in & commit;
    mem_we  = MemWrite_in & commit;
    count_d = count_q + CNT_W'(commit);
  end

  assign disp_out    = disp_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_de_execucao.sv
// Scoreboard bench for sequenciador_de_execucao: stimulus queues expected commits,
// a negedge monitor pops and compares them whenever pc_en is seen.
module tb_sequenciador_de_execucao;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        regWrite_in, MemWrite_in, confirm;
  logic [31:0] rs1_data;
  logic        pc_en, reg_we, mem_we, alu_busy, wait_in, halted;
  logic [31:0] disp_out;
  logic [3:0]  instr_count;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rw;
    logic        mw;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc = 0;
  logic [3:0]  model_cnt = 4'd0;

  sequenciador_de_execucao #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7),
    .regWrite_in(regWrite_in), .MemWrite_in(MemWrite_in), .confirm(confirm),
    .rs1_data(rs1_data), .pc_en(pc_en), .reg_we(reg_we), .mem_we(mem_we),
    .alu_busy(alu_busy), .wait_in(wait_in), .halted(halted),
    .disp_out(disp_out), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pc_en pulse must match the oldest queued commit
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_commit: actual none required commit at cycle %0d", e.cyc);
    end
    if (pc_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: actual pc_en=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("commit_cycle", cyc, e.cyc);
        chk("reg_we", 32'(reg_we), 32'(e.rw));
        chk("mem_we", 32'(mem_we), 32'(e.mw));
        chk("count_at_commit", 32'(instr_count), 32'(e.cnt));
      end
    end
  end

  task automatic expect_commit(input int n, input logic rw, input logic mw);
    exp_t e;
    e.cyc = cyc + 32'(n) - 32'd1;
    e.rw  = rw;
    e.mw  = mw;
    e.cnt = model_cnt;
    sb.push_back(e);
    model_cnt = model_cnt + 4'd1;
  endtask

  // Present an instruction for n cycles; it must retire in its last cycle
  task automatic issue(input logic [6:0] op, input logic [2:0] ff3, input logic [6:0] ff7,
                       input logic rw, input logic mw, input logic [31:0] rs1,
                       input int n, output int busy);
    opcode = op; f3 = ff3; f7 = ff7;
    regWrite_in = rw; MemWrite_in = mw; rs1_data = rs1;
    expect_commit(n, rw, mw);
    busy = 0;
    repeat (n) begin
      @(negedge clk);
      if (alu_busy === 1'b1) busy++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: actual timeout required test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, hcnt, pcnt;
    reset = 1'b1; opcode = 7'd51; f3 = 3'd0; f7 = 7'd0;
    regWrite_in = 1'b1; MemWrite_in = 1'b0; confirm = 1'b0; rs1_data = 32'h0;

    // Reset holds everything low even with an add on the bus
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_busy", 32'(alu_busy), 0);
    chk("rst_wait", 32'(wait_in), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_count", 32'(instr_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three back-to-back adds
    for (int i = 0; i < 3; i++) issue(7'd51, 3'd0, 7'd0, 1'b1, 1'b0, 32'h0, 1, busy);
    issue(7'd51, 3'd3, 7'd0, 1'b1, 1'b0, 32'h0, 4, busy);
    chk("mul_busy_cycles", 32'(busy), 3);
    issue(7'd51, 3'd3, 7'd32, 1'b1, 1'b0, 32'h0, 32, busy);
    chk("div_busy_cycles", 32'(busy), 31);

    // IN with confirm already high: no edge, must wait
    confirm = 1'b1; opcode = 7'd55; f3 = 3'd0; f7 = 7'd0; regWrite_in = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) confirm = 1'b0;
      @(negedge clk);
      chk("in_wait", 32'(wait_in), 1);
      chk("in_reg_we_low", 32'(reg_we), 0);
      @(posedge clk); #1;
    end
    confirm = 1'b1;
    expect_commit(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("in_edge_reg_we", 32'(reg_we), 1);
    @(posedge clk); #1;

    // OUT then sw
    issue(7'd23, 3'd0, 7'd0, 1'b0, 1'b0, 32'h0000_00A5, 1, busy);
    issue(7'd35, 3'd2, 7'd0, 1'b0, 1'b1, 32'h0, 1, busy);

    // Div aborted by reset in its 10th cycle
    opcode = 7'd51; f3 = 3'd3; f7 = 7'd32; regWrite_in = 1'b1; MemWrite_in = 1'b0;
    @(negedge clk);
    chk("disp_after_out", disp_out, 32'hA5);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(alu_busy), 1);
    chk("abort_no_commit", 32'(pc_en), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 4'd0;

    // 17 adds wrap the 4-bit counter to 1; the first proves RUN right after reset
    for (int i = 0; i < 17; i++) begin
      issue(7'd51, 3'd0, 7'd0, 1'b1, 1'b0, 32'h0, 1, busy);
      if (i == 0) chk("run_after_abort", 32'(busy), 0);
    end

    // HALT freezes the core
    opcode = 7'd63; f3 = 3'd0; f7 = 7'd0; regWrite_in = 1'b0;
    hcnt = 0; pcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (halted === 1'b1) hcnt++;
      if (pc_en === 1'b1) pcnt++;
      @(posedge clk); #1;
    end
    chk("halted_cycles", 32'(hcnt), 99);
    chk("halt_pc_en", 32'(pcnt), 0);
    chk("halt_count_wrap", 32'(instr_count), 1);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_halt_halted", 32'(halted), 0);
    chk("post_halt_count", 32'(instr_count), 0);
    chk("post_halt_disp", disp_out, 0);
    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_de_execucao.md
Name: sequenciador_de_execucao

Overview:
- Multi-cycle execution sequencer for the single-cycle RISC-V-style core.
- Decodes the current instruction's opcode/f3/f7 and decides when the PC advances and when register/memory writes commit.
- Stretches MUL/DIV over fixed ALU latencies, stalls IN until the user confirm button, latches OUT data into the display register, and freezes the core on HALT.
- Sits between the control unit outputs and the PC/register-file/data-memory enables.

Parameters:
- MUL_CYCLES, 4, total cycles a mul occupies (>=1).
- DIV_CYCLES, 32, total cycles a div occupies (>=1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  current instruction opcode.
- f3  input  3  current instruction funct3.
- f7  input  7  current instruction funct7.
- regWrite_in  input  1  regWrite from control unit.
- MemWrite_in  input  1  MemWrite from control unit.
- confirm  input  1  user confirm button, already synchronized, level.
- rs1_data  input  32  register operand used by OUT.
- pc_en  output  1  PC load enable (one pulse per retired instruction).
- reg_we  output  1  gated register-file write enable.
- mem_we  output  1  gated data-memory write enable.
- alu_busy  output  1  high while a MUL/DIV is in progress.
- wait_in  output  1  high while waiting for confirm.
- halted  output  1  high in HALTED.
- disp_out  output  32  display register.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Reset: state=RUN, counters 0, disp_out=0, instr_count=0, confirm edge detector prev=1 (button held through reset gives no edge). All outputs 0 after reset.
- commit is an internal combinational signal. pc_en=commit. reg_we=regWrite_in&commit. mem_we=MemWrite_in&commit.
- RUN, with the instruction classed from the current opcode/f3/f7:
  - MUL (opcode 51, f3 3, f7 0): if MUL_CYCLES==1, commit now; else load cnt=MUL_CYCLES-2 and go to MULTI with no commit.
  - DIV (opcode 51, f3 3, f7 32): same rule using DIV_CYCLES.
  - IN (opcode 55): go to WAIT_IN, no commit.
  - HALT (opcode 63): go to HALTED, no commit.
  - OUT (opcode 23): commit; disp_out<=rs1_data at this edge.
  - Anything else: commit this cycle; stay in RUN.
- MULTI: alu_busy=1. If cnt==0, commit and return to RUN; else cnt-=1. Opcode/f3/f7 are ignored here (PC frozen). An N-cycle op retires in exactly N cycles.
- WAIT_IN: wait_in=1. A rising edge on confirm (confirm=1, prev=0) commits that cycle and returns to RUN. prev updates every cycle in all states.
- Confirm edges outside WAIT_IN are discarded, not queued.
- HALTED: halted=1, commit=0. Exit only by reset.
- instr_count increments by 1 on every commit and wraps modulo 2^CNT_W. Frozen in HALTED.
- Reset in any state, including mid-MULTI or WAIT_IN, aborts the instruction with no commit. The next cycle is RUN.

Optional Feature:
- SINGLE_STEP_EN adds inputs step_mode (1) and step (1, synchronized level).
- With step_mode=1, RUN only evaluates the instruction in a cycle where step has a rising edge (own edge detector, prev reset to 1). Otherwise it holds with no commit.
- MULTI and WAIT_IN run as normal once entered.
- Without the macro, the ports are absent and RUN evaluates every cycle.

Test Plan:
- Reset, then 3 add instructions (opcode 51, f3 0, f7 0) with regWrite_in=1 -> pc_en/reg_we high 3 consecutive cycles; instr_count=3.
- Div with DIV_CYCLES=32 -> alu_busy high 31 cycles; pc_en single pulse at cycle 32; instr_count +1. Mul with MUL_CYCLES=4 -> retires at cycle 4.
- IN with confirm held high before the instruction arrives -> stays WAIT_IN. confirm low 2 cycles, then high -> one commit; reg_we=1 that cycle only.
- OUT with rs1_data=0x0000_00A5 -> disp_out=0xA5 next cycle. Then sw (opcode 35, MemWrite_in=1) -> mem_we pulses once.
- HALT -> halted=1, pc_en=0 for 100 cycles, instr_count unchanged. Reset -> RUN, count 0, disp_out 0.
- Reset asserted at cycle 10 of a div -> no commit; RUN next cycle. CNT_W=4 with 17 retired instructions -> instr_count=1.
